// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared types for the multicycle controller:
// state encoding, opcodes, ALU function codes, decode bundle.
package multicycle_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_DEC   = 3'd1,
    S_EX    = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_PCUPD = 3'd5,
    S_TRAP  = 3'd6
  } state_e;

  localparam logic [5:0] OP_ALU  = 6'b100000;
  localparam logic [5:0] OP_LI   = 6'b111000;
  localparam logic [5:0] OP_LUI  = 6'b111001;
  localparam logic [5:0] OP_ADDI = 6'b110000;
  localparam logic [5:0] OP_ANDI = 6'b110010;
  localparam logic [5:0] OP_ORI  = 6'b110011;
  localparam logic [5:0] OP_B    = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000000;
  localparam logic [5:0] OP_BNE  = 6'b000001;
  localparam logic [5:0] OP_LW   = 6'b001111;
  localparam logic [5:0] OP_SW   = 6'b011111;
  localparam logic [5:0] OP_LB   = 6'b000011;
  localparam logic [5:0] OP_SB   = 6'b000111;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_IMM, C_B,
    C_BEQ, C_BNE, C_LW, C_SW,
    C_LB, C_SB, C_ILL
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [3:0] imm_fn;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode:
// latched IR -> instruction class, immediate ALU func, illegal flag.
module ctrl_decode
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter bit ENABLE_BYTE_OPS = 1'b1
) (
  input  logic [31:0] ir_i,
  output dec_t        dec_o
);

  logic [5:0] op;
  logic       nz;

  assign op = ir_i[31:26];
  assign nz = |ir_i;

  // all-zero word is a nop even though its opcode aliases beq
  always_comb begin
    dec_o.cls    = C_ILL;
    dec_o.imm_fn = FN_ADD;
    unique case (1'b1)
      !nz:
        dec_o.cls = C_NOP;
      (op == OP_ALU):
        dec_o.cls = C_ALU;
      (op == OP_LI),
      (op == OP_LUI),
      (op == OP_ADDI):
        dec_o.cls = C_IMM;
      (op == OP_ANDI): begin
        dec_o.cls    = C_IMM;
        dec_o.imm_fn = FN_AND;
      end
      (op == OP_ORI): begin
        dec_o.cls    = C_IMM;
        dec_o.imm_fn = FN_OR;
      end
      (op == OP_B):
        dec_o.cls = C_B;
      (nz && op == OP_BEQ):
        dec_o.cls = C_BEQ;
      (op == OP_BNE):
        dec_o.cls = C_BNE;
      (op == OP_LW):
        dec_o.cls = C_LW;
      (op == OP_SW):
        dec_o.cls = C_SW;
      (op == OP_LB):
        dec_o.cls = ENABLE_BYTE_OPS ? C_LB : C_ILL;
      (op == OP_SB):
        dec_o.cls = ENABLE_BYTE_OPS ? C_SB : C_ILL;
      default: ;
    endcase
    dec_o.illegal = (dec_o.cls == C_ILL);
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle controller: IR latch, per-class phase sequencing,
// memory handshake with timeout, illegal-opcode trap.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int ALU_FUNC_W      = 4,
  parameter bit MEM_HANDSHAKE   = 1'b1,
  parameter int MEM_TIMEOUT     = 16,
  parameter bit ENABLE_BYTE_OPS = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [31:0]           Instr,
  input  logic                  Zero,
  input  logic                  Mem_Ready,
  output logic                  Instr_LdEn,
  output logic                  PC_Sel,
  output logic                  PC_LdEn,
  output logic                  RF_B_sel,
  output logic                  RF_WrData_sel,
  output logic                  RF_WEn,
  output logic                  ALU_Bin_sel,
  output logic [ALU_FUNC_W-1:0] ALU_func,
  output logic                  MEM_WrEn,
  output logic                  Mem_In_Out_Sel,
  output logic                  Busy,
  output logic                  Illegal_Instr,
  output logic [2:0]            State
);

  localparam int CW =
    (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_e        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic          taken_q, taken_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dec_t          dec;

  logic is_ld, is_st, is_byte, is_br;
  logic mem_done, to_hit;

  ctrl_decode #(
    .ENABLE_BYTE_OPS(ENABLE_BYTE_OPS)
  ) u_decode (
    .ir_i (ir_q),
    .dec_o(dec)
  );

  assign is_ld   = (dec.cls == C_LW) || (dec.cls == C_LB);
  assign is_st   = (dec.cls == C_SW) || (dec.cls == C_SB);
  assign is_byte = (dec.cls == C_LB) || (dec.cls == C_SB);
  assign is_br   = (dec.cls == C_BEQ) || (dec.cls == C_BNE);

  assign mem_done = !MEM_HANDSHAKE || Mem_Ready;
  assign to_hit   = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IF;
      ir_q    <= '0;
      taken_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      taken_q <= taken_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    taken_d = taken_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IF: begin
        ir_d    = Instr;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (dec.illegal)
          state_d = S_TRAP;
        else if (dec.cls == C_NOP || dec.cls == C_B)
          state_d = S_PCUPD;
        else
          state_d = S_EX;
      end
      S_EX: begin
        cnt_d = '0;
        if (is_ld || is_st)
          state_d = S_MEM;
        else if (is_br) begin
          taken_d = (dec.cls == C_BEQ) ? Zero : !Zero;
          state_d = S_PCUPD;
        end else
          state_d = S_WB;
      end
      // a ready in the same cycle the count expires still completes
      S_MEM: begin
        if (mem_done) begin
          cnt_d   = '0;
          state_d = is_ld ? S_WB : S_PCUPD;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (to_hit)
            state_d = S_TRAP;
        end
      end
      S_WB:    state_d = S_PCUPD;
      S_PCUPD: state_d = S_IF;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    Instr_LdEn     = 1'b0;
    PC_Sel         = 1'b0;
    PC_LdEn        = 1'b0;
    RF_B_sel       = 1'b0;
    RF_WrData_sel  = 1'b0;
    RF_WEn         = 1'b0;
    ALU_Bin_sel    = 1'b0;
    ALU_func       = '0;
    MEM_WrEn       = 1'b0;
    Mem_In_Out_Sel = 1'b0;
    Busy           = 1'b0;
    Illegal_Instr  = 1'b0;
    State          = S_IF;
    if (!Reset) begin
      State = state_q;
      case (state_q)
        S_IF: Instr_LdEn = 1'b1;
        S_DEC: begin
          Busy     = 1'b1;
          RF_B_sel = (dec.cls == C_IMM) || is_br;
        end
        S_EX: begin
          Busy = 1'b1;
          case (dec.cls)
            C_ALU: ALU_func = ir_q[ALU_FUNC_W-1:0];
            C_IMM: begin
              RF_B_sel    = 1'b1;
              ALU_Bin_sel = 1'b1;
              ALU_func    = ALU_FUNC_W'(dec.imm_fn);
            end
            C_BEQ, C_BNE: begin
              RF_B_sel = 1'b1;
              ALU_func = ALU_FUNC_W'(FN_SUB);
            end
            C_LW, C_LB: ALU_Bin_sel = 1'b1;
            C_SW, C_SB: begin
              RF_B_sel    = 1'b1;
              ALU_Bin_sel = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          Busy           = 1'b1;
          ALU_Bin_sel    = 1'b1;
          RF_B_sel       = is_st;
          MEM_WrEn       = is_st;
          Mem_In_Out_Sel = is_byte;
        end
        S_WB: begin
          Busy   = 1'b1;
          RF_WEn = 1'b1;
          case (dec.cls)
            C_ALU: ALU_func = ir_q[ALU_FUNC_W-1:0];
            C_IMM: begin
              RF_B_sel    = 1'b1;
              ALU_Bin_sel = 1'b1;
              ALU_func    = ALU_FUNC_W'(dec.imm_fn);
            end
            C_LW, C_LB: begin
              RF_WrData_sel  = 1'b1;
              Mem_In_Out_Sel = is_byte;
            end
            default: ;
          endcase
        end
        S_PCUPD: begin
          Busy     = 1'b1;
          PC_LdEn  = 1'b1;
          RF_B_sel = is_br;
          PC_Sel   = (dec.cls == C_B) || (is_br && taken_q);
        end
        S_TRAP: Illegal_Instr = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: per-cycle expected
// control vectors queued with the stimulus, popped each cycle.
module tb_multicycle_ctrl_fsm;

  localparam logic [2:0] S_IF    = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_EX    = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_PCUPD = 3'd5;
  localparam logic [2:0] S_TRAP  = 3'd6;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Instr = '0;
  logic        Zero = 1'b0;
  logic        Mem_Ready = 1'b0;

  logic       ld, psel, pld, bsel, wds, wen, bin;
  logic [3:0] fn;
  logic       wr, byt, busy, ill;
  logic [2:0] st;

  logic       n_ld, n_psel, n_pld, n_bsel, n_wds, n_wen, n_bin;
  logic [3:0] n_fn;
  logic       n_wr, n_byt, n_busy, n_ill;
  logic [2:0] n_st;

  typedef struct packed {
    logic ld, psel, pld, bsel, wds, wen, bin;
    logic [3:0] fn;
    logic wr, byt, busy, ill;
    logic [2:0] st;
  } obs_t;

  typedef struct {
    logic [31:0] instr;
    logic        z;
    logic        r;
    obs_t        e;
  } ent_t;

  ent_t sb[$];
  obs_t nb_sb[$];
  obs_t obs, nb_obs;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 Clk = ~Clk;

  multicycle_ctrl_fsm u_dut (
    .Clk(Clk), .Reset(Reset), .Instr(Instr),
    .Zero(Zero), .Mem_Ready(Mem_Ready),
    .Instr_LdEn(ld), .PC_Sel(psel), .PC_LdEn(pld),
    .RF_B_sel(bsel), .RF_WrData_sel(wds), .RF_WEn(wen),
    .ALU_Bin_sel(bin), .ALU_func(fn), .MEM_WrEn(wr),
    .Mem_In_Out_Sel(byt), .Busy(busy),
    .Illegal_Instr(ill), .State(st)
  );

  multicycle_ctrl_fsm #(.ENABLE_BYTE_OPS(1'b0)) u_nb (
    .Clk(Clk), .Reset(Reset), .Instr(Instr),
    .Zero(Zero), .Mem_Ready(Mem_Ready),
    .Instr_LdEn(n_ld), .PC_Sel(n_psel), .PC_LdEn(n_pld),
    .RF_B_sel(n_bsel), .RF_WrData_sel(n_wds), .RF_WEn(n_wen),
    .ALU_Bin_sel(n_bin), .ALU_func(n_fn), .MEM_WrEn(n_wr),
    .Mem_In_Out_Sel(n_byt), .Busy(n_busy),
    .Illegal_Instr(n_ill), .State(n_st)
  );

  always_comb begin
    obs = {ld, psel, pld, bsel, wds, wen, bin, fn,
           wr, byt, busy, ill, st};
    nb_obs = {n_ld, n_psel, n_pld, n_bsel, n_wds, n_wen,
              n_bin, n_fn, n_wr, n_byt, n_busy, n_ill, n_st};
  end

  function automatic obs_t mk(
    input logic [2:0] s,
    input logic a_ld, a_psel, a_pld, a_bsel, a_wds,
    input logic a_wen, a_bin,
    input logic [3:0] a_fn,
    input logic a_wr, a_byt
  );
    logic b;
    b = (s != S_IF) && (s != S_TRAP);
    return {a_ld, a_psel, a_pld, a_bsel, a_wds, a_wen,
            a_bin, a_fn, a_wr, a_byt, b, s == S_TRAP, s};
  endfunction

  function automatic void push(
    input logic [31:0] i, input logic z, input logic r,
    input obs_t e
  );
    ent_t t;
    t.instr = i;
    t.z = z;
    t.r = r;
    t.e = e;
    sb.push_back(t);
  endfunction

  task automatic tick(input ent_t t,
                      output obs_t o, output obs_t onb);
    Instr = t.instr;
    Zero = t.z;
    Mem_Ready = t.r;
    #1;
    o = obs;
    onb = nb_obs;
    @(negedge Clk);
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Reset = 1'b1;
    Instr = '0;
    Zero = 1'b0;
    Mem_Ready = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset;
    obs_t e;
    @(negedge Clk);
    for (int k = 0; k < 2; k++) begin
      n_chk += 2;
      if (obs !== '0) begin
        n_fail++;
        $display("FAIL reset: got %h want 0", obs);
      end
      if (nb_obs !== '0) begin
        n_fail++;
        $display("FAIL reset_nb: got %h want 0", nb_obs);
      end
      @(negedge Clk);
    end
    Reset = 1'b0;
    #1;
    e = mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL reset_rel: got %h want %h", obs, e);
    end
    @(negedge Clk);
  endtask

  task automatic test_short(input logic [31:0] i,
                            input logic ps, input string nm);
    ent_t t;
    obs_t o, onb;
    int c;
    do_reset();
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_DEC, 0, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_PCUPD, 0, ps,1,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    c = 1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      tick(t, o, onb);
      n_chk++;
      if (o !== t.e) begin
        n_fail++;
        $display("FAIL %s c%0d: got %h want %h", nm, c, o, t.e);
      end
      c++;
    end
  endtask

  task automatic test_alu;
    ent_t t;
    obs_t o, onb;
    int c;
    logic [31:0] i, j;
    i = 32'h8022_1003;
    j = 32'hA800_0000;
    do_reset();
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    push(j, 0, 0, mk(S_DEC, 0, 0,0,0,0,0,0, 0, 0,0));
    push(j, 0, 0, mk(S_EX, 0, 0,0,0,0,0,0, 3, 0,0));
    push(j, 0, 0, mk(S_WB, 0, 0,0,0,0,1,0, 3, 0,0));
    push(j, 0, 0, mk(S_PCUPD, 0, 0,1,0,0,0,0, 0, 0,0));
    c = 1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      tick(t, o, onb);
      n_chk++;
      if (o !== t.e) begin
        n_fail++;
        $display("FAIL alu c%0d: got %h want %h", c, o, t.e);
      end
      c++;
    end
  endtask

  task automatic test_branch(input logic [31:0] i,
                             input logic z, input logic tk,
                             input string nm);
    ent_t t;
    obs_t o, onb;
    int c;
    do_reset();
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_DEC, 0, 0,0,1,0,0,0, 0, 0,0));
    push(i, z, 0, mk(S_EX, 0, 0,0,1,0,0,0, 1, 0,0));
    push(i, 0, 0, mk(S_PCUPD, 0, tk,1,1,0,0,0, 0, 0,0));
    c = 1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      tick(t, o, onb);
      n_chk++;
      if (o !== t.e) begin
        n_fail++;
        $display("FAIL %s c%0d: got %h want %h", nm, c, o, t.e);
      end
      c++;
    end
  endtask

  task automatic test_imm(input logic [31:0] i,
                          input logic [3:0] f, input string nm);
    ent_t t;
    obs_t o, onb;
    int c;
    do_reset();
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_DEC, 0, 0,0,1,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_EX, 0, 0,0,1,0,0,1, f, 0,0));
    push(i, 0, 0, mk(S_WB, 0, 0,0,1,0,1,1, f, 0,0));
    push(i, 0, 0, mk(S_PCUPD, 0, 0,1,0,0,0,0, 0, 0,0));
    c = 1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      tick(t, o, onb);
      n_chk++;
      if (o !== t.e) begin
        n_fail++;
        $display("FAIL %s c%0d: got %h want %h", nm, c, o, t.e);
      end
      c++;
    end
  endtask

  task automatic test_mem(input logic [31:0] i, input logic isld,
                          input logic bt, input int waits,
                          input string nm);
    ent_t t;
    obs_t o, onb;
    int c;
    do_reset();
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_DEC, 0, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_EX, 0, 0,0,!isld,0,0,1, 0, 0,0));
    for (int k = 0; k <= waits; k++)
      push(i, 0, k == waits,
           mk(S_MEM, 0, 0,0,!isld,0,0,1, 0, !isld,bt));
    if (isld)
      push(i, 0, 0, mk(S_WB, 0, 0,0,0,1,1,0, 0, 0,bt));
    push(i, 0, 0, mk(S_PCUPD, 0, 0,1,0,0,0,0, 0, 0,0));
    c = 1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      tick(t, o, onb);
      n_chk++;
      if (o !== t.e) begin
        n_fail++;
        $display("FAIL %s c%0d: got %h want %h", nm, c, o, t.e);
      end
      c++;
    end
  endtask

  task automatic test_timeout;
    ent_t t;
    obs_t o, onb, e;
    int c;
    logic [31:0] i;
    i = 32'h3C22_1004;
    do_reset();
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_DEC, 0, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_EX, 0, 0,0,0,0,0,1, 0, 0,0));
    for (int k = 0; k < 16; k++)
      push(i, 0, 0, mk(S_MEM, 0, 0,0,0,0,0,1, 0, 0,0));
    for (int k = 0; k < 3; k++)
      push(i, 0, 1, mk(S_TRAP, 0, 0,0,0,0,0,0, 0, 0,0));
    c = 1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      tick(t, o, onb);
      n_chk++;
      if (o !== t.e) begin
        n_fail++;
        $display("FAIL timeout c%0d: got %h want %h", c, o, t.e);
      end
      c++;
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL trap_reset: got %h want 0", obs);
    end
    Reset = 1'b0;
    #1;
    e = mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL trap_exit: got %h want %h", obs, e);
    end
  endtask

  task automatic test_illegal;
    ent_t t;
    obs_t o, onb;
    int c;
    logic [31:0] i;
    i = 32'hA822_1004;
    do_reset();
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_DEC, 0, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 1, mk(S_TRAP, 0, 0,0,0,0,0,0, 0, 0,0));
    push(i, 1, 1, mk(S_TRAP, 0, 0,0,0,0,0,0, 0, 0,0));
    c = 1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      tick(t, o, onb);
      n_chk++;
      if (o !== t.e) begin
        n_fail++;
        $display("FAIL illegal c%0d: got %h want %h", c, o, t.e);
      end
      c++;
    end
  endtask

  task automatic test_byte_disabled;
    ent_t t;
    obs_t o, onb, en;
    int c;
    logic [31:0] i;
    i = 32'h0C22_1004;
    do_reset();
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_DEC, 0, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_EX, 0, 0,0,0,0,0,1, 0, 0,0));
    push(i, 0, 1, mk(S_MEM, 0, 0,0,0,0,0,1, 0, 0,1));
    nb_sb.push_back(mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    nb_sb.push_back(mk(S_DEC, 0, 0,0,0,0,0,0, 0, 0,0));
    nb_sb.push_back(mk(S_TRAP, 0, 0,0,0,0,0,0, 0, 0,0));
    nb_sb.push_back(mk(S_TRAP, 0, 0,0,0,0,0,0, 0, 0,0));
    c = 1;
    while (sb.size() > 0 && nb_sb.size() > 0) begin
      t = sb.pop_front();
      en = nb_sb.pop_front();
      tick(t, o, onb);
      n_chk += 2;
      if (o !== t.e) begin
        n_fail++;
        $display("FAIL lb_on c%0d: got %h want %h", c, o, t.e);
      end
      if (onb !== en) begin
        n_fail++;
        $display("FAIL lb_off c%0d: got %h want %h", c, onb, en);
      end
      c++;
    end
  endtask

  task automatic test_reset_mid;
    ent_t t;
    obs_t o, onb, e;
    int c;
    logic [31:0] i;
    i = 32'h7C22_1004;
    do_reset();
    push(i, 0, 0, mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_DEC, 0, 0,0,0,0,0,0, 0, 0,0));
    push(i, 0, 0, mk(S_EX, 0, 0,0,1,0,0,1, 0, 0,0));
    push(i, 0, 0, mk(S_MEM, 0, 0,0,1,0,0,1, 0, 1,0));
    c = 1;
    while (sb.size() > 0) begin
      t = sb.pop_front();
      tick(t, o, onb);
      n_chk++;
      if (o !== t.e) begin
        n_fail++;
        $display("FAIL midrst c%0d: got %h want %h", c, o, t.e);
      end
      c++;
    end
    Reset = 1'b1;
    @(negedge Clk);
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL midrst_hold: got %h want 0", obs);
    end
    Reset = 1'b0;
    #1;
    e = mk(S_IF, 1, 0,0,0,0,0,0, 0, 0,0);
    n_chk++;
    if (obs !== e) begin
      n_fail++;
      $display("FAIL midrst_rel: got %h want %h", obs, e);
    end
  endtask

  initial begin
    test_reset();
    test_short(32'h0000_0000, 1'b0, "nop");
    test_short(32'hFC00_0010, 1'b1, "b");
    test_alu();
    test_branch(32'h0022_1004, 1'b1, 1'b1, "beq_z1");
    test_branch(32'h0022_1004, 1'b0, 1'b0, "beq_z0");
    test_branch(32'h0422_1004, 1'b1, 1'b0, "bne_z1");
    test_branch(32'h0422_1004, 1'b0, 1'b1, "bne_z0");
    test_imm(32'hC022_1004, 4'd0, "addi");
    test_imm(32'hC822_1004, 4'd2, "andi");
    test_imm(32'hCC22_1004, 4'd3, "ori");
    test_imm(32'hE022_1004, 4'd0, "li");
    test_imm(32'hE422_1004, 4'd0, "lui");
    test_mem(32'h7C22_1004, 1'b0, 1'b0, 3, "sw_wait");
    test_mem(32'h1C22_1004, 1'b0, 1'b1, 0, "sb");
    test_mem(32'h3C22_1004, 1'b1, 1'b0, 2, "lw_wait");
    test_mem(32'h0C22_1004, 1'b1, 1'b1, 0, "lb");
    test_timeout();
    test_illegal();
    test_byte_disabled();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
